// File: rtl/uart_pkg.sv
// Shared UART definitions: frame line levels, payload width and receiver state encoding.
// Also used by the transmitter state machine.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART receiver. It produces a one-cycle tick at the
// half-bit point (half_i=1) or at the full-bit point (half_i=0), counted from the last restart.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic half_i,
    output logic tick_c_o
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF     = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned HALF_TGT = (HALF == 0) ? 0 : HALF - 1;
    localparam int unsigned FULL_TGT = CLKS_PER_BIT - 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter holds 0 on the restart edge, so the tick at value N lands N+1 edges later.
    always_comb begin
        tick_c_o = (cnt_q == (half_i ? CNT_W'(HALF_TGT) : CNT_W'(FULL_TGT)));
        cnt_d    = cnt_q + CNT_W'(1);
        if (restart_i || tick_c_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a fixed clocks-per-bit count; pulses `received` once per valid frame.
// Define UART_RX_FRAME_ERR_EN to add the `frame_err` strobe for a bad stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 received
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);

    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned HALF_BIT  = (CLKS_PER_BIT - 1) / 2;

    uart_rx_state_t         state_q;
    uart_rx_state_t         state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   data_q;
    logic [DATA_BITS-1:0]   data_d;
    logic                   received_q;
    logic                   received_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic                   frame_err_q;
    logic                   frame_err_d;
`endif

    logic baud_restart_c;
    logic baud_half_c;
    logic baud_tick_c;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (baud_restart_c),
        .half_i    (baud_half_c),
        .tick_c_o  (baud_tick_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        received_d     = 1'b0;
        baud_restart_c = 1'b0;
        baud_half_c    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                baud_restart_c = 1'b1;
                if (rx == UART_START_LVL) begin
                    bit_cnt_d = '0;
                    // With no half-bit delay the detecting edge doubles as the start check.
                    state_d   = (HALF_BIT == 0) ? DATA : START;
                end
            end
            START: begin
                baud_half_c = 1'b1;
                if (baud_tick_c) begin
                    state_d = (rx == UART_START_LVL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (baud_tick_c) begin
                    shift_d   = {rx, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick_c) begin
                    if (rx == UART_STOP_LVL) begin
                        data_d     = shift_q;
                        received_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        frame_err_d = 1'b1;
`endif
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be parsed as a run of 0x00 frames.
                if (rx == UART_IDLE_LVL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            received_q  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            received_q  <= received_d;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign data     = data_q;
    assign received = received_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 and 16 clocks per bit, against a bit-stream parser model.
module tb_uart_rx;

    localparam int N = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx1;
    logic       rx16;
    logic [7:0] data1;
    logic [7:0] data16;
    logic       recv1;
    logic       recv16;
`ifdef UART_RX_FRAME_ERR_EN
    logic       ferr1;
    logic       ferr16;
`endif

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx1),
        .data     (data1),
        .received (recv1)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(ferr1)
`endif
    );

    uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx16),
        .data     (data16),
        .received (recv16)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(ferr16)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic       rxs      [N];
    int         len;
    logic       exp_recv [N];
    logic       exp_ferr [N];
    logic [7:0] exp_byte [N];
    logic [7:0] exp_data [N];
    logic [7:0] model_data1;
    logic [7:0] model_data16;
    logic [7:0] got_q[$];
    int         strobe_q[$];
    int         ferr_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_level(input logic v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (len < N) begin
                rxs[len] = v;
                len++;
            end
        end
    endtask

    task automatic add_frame(input int c, input logic [7:0] b, input logic stop_bit);
        add_level(1'b0, c);
        for (int k = 0; k < 8; k++) add_level(b[k], c);
        add_level(stop_bit, c);
    endtask

    // Parse the line level seen at each edge into expected strobes, per the framing rules.
    task automatic build_model(input int c, input int n, input logic [7:0] init_d);
        int h, i, t0, stp, j;
        logic [7:0] b;
        logic [7:0] d;
        h = (c - 1) / 2;
        for (int e = 0; e < n; e++) begin
            exp_recv[e] = 1'b0;
            exp_ferr[e] = 1'b0;
            exp_byte[e] = 8'h00;
        end
        i = 0;
        while (i < n) begin
            if (rxs[i]) begin
                i++;
            end else begin
                t0 = i;
                if (t0 + h >= n) break;
                if (rxs[t0 + h]) begin
                    i = t0 + h + 1;
                end else begin
                    stp = t0 + h + 9 * c;
                    if (stp >= n) break;
                    for (int k = 1; k <= 8; k++) b[k-1] = rxs[t0 + h + k * c];
                    if (rxs[stp]) begin
                        exp_recv[stp] = 1'b1;
                        exp_byte[stp] = b;
                        i = stp + 1;
                    end else begin
                        exp_ferr[stp] = 1'b1;
                        j = stp + 1;
                        while (j < n && !rxs[j]) j++;
                        i = j + 1;
                    end
                end
            end
        end
        d = init_d;
        for (int e = 0; e < n; e++) begin
            if (exp_recv[e]) d = exp_byte[e];
            exp_data[e] = d;
        end
    endtask

    task automatic run(input int c);
        build_model(c, len, (c == 1) ? model_data1 : model_data16);
        got_q.delete();
        strobe_q.delete();
        ferr_seen = 0;
        for (int e = 0; e < len; e++) begin
            @(negedge clk);
            if (c == 1) rx1 = rxs[e];
            else        rx16 = rxs[e];
            @(posedge clk);
            #1;
            if (c == 1) begin
                check($sformatf("recv1@%0d", e), 32'(recv1), 32'(exp_recv[e]));
                check($sformatf("data1@%0d", e), 32'(data1), 32'(exp_data[e]));
                if (recv1) begin
                    got_q.push_back(data1);
                    strobe_q.push_back(e);
                end
`ifdef UART_RX_FRAME_ERR_EN
                check($sformatf("ferr1@%0d", e), 32'(ferr1), 32'(exp_ferr[e]));
                if (ferr1) ferr_seen++;
`endif
            end else begin
                check($sformatf("recv16@%0d", e), 32'(recv16), 32'(exp_recv[e]));
                check($sformatf("data16@%0d", e), 32'(data16), 32'(exp_data[e]));
                if (recv16) begin
                    got_q.push_back(data16);
                    strobe_q.push_back(e);
                end
`ifdef UART_RX_FRAME_ERR_EN
                check($sformatf("ferr16@%0d", e), 32'(ferr16), 32'(exp_ferr[e]));
                if (ferr16) ferr_seen++;
`endif
            end
        end
        if (len > 0) begin
            if (c == 1) model_data1 = exp_data[len-1];
            else        model_data16 = exp_data[len-1];
        end
        len = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data1  = 8'h00;
        model_data16 = 8'h00;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [3];
        logic [7:0] lb  [8];
        logic [7:0] rb;
        int         cc;
        b2b = '{8'h48, 8'h69, 8'h0A};
        lb  = '{8'h00, 8'hFF, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
        len = 0;
        rst = 1'b1;
        rx1 = 1'b1;
        rx16 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data1", 32'(data1), 32'h00);
        check("rst_recv1", 32'(recv1), 32'h0);
        check("rst_data16", 32'(data16), 32'h00);
        check("rst_recv16", 32'(recv16), 32'h0);
        rst = 1'b0;
        model_data1  = 8'h00;
        model_data16 = 8'h00;

        // Single 'A' frame, one bit per clock
        add_level(1'b1, 3);
        add_frame(1, 8'h41, 1'b1);
        add_level(1'b1, 5);
        run(1);
        check("A_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("A_byte", 32'(got_q[0]), 32'h41);
        if (strobe_q.size() >= 1) check("A_latency", 32'(strobe_q[0]), 32'd12);
        check("A_held", 32'(data1), 32'h41);

        // Back-to-back frames, no idle gap
        add_level(1'b1, 2);
        for (int i = 0; i < 3; i++) add_frame(1, b2b[i], 1'b1);
        add_level(1'b1, 4);
        run(1);
        check("b2b_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check($sformatf("b2b_byte%0d", i), 32'(got_q[i]), 32'(b2b[i]));
        for (int i = 1; i < strobe_q.size(); i++)
            check($sformatf("b2b_gap%0d", i), 32'(strobe_q[i] - strobe_q[i-1]), 32'd10);

        // Framing error followed by a 20-clock break
        add_level(1'b1, 2);
        add_frame(1, 8'h3C, 1'b1);
        add_frame(1, 8'hA5, 1'b0);
        add_level(1'b0, 20);
        add_level(1'b1, 5);
        run(1);
        check("ferr_count", 32'(got_q.size()), 32'd1);
        check("ferr_held", 32'(data1), 32'h3C);
`ifdef UART_RX_FRAME_ERR_EN
        check("ferr_pulses", 32'(ferr_seen), 32'd1);
`endif

        // Glitch rejection then a full frame at 16 clocks per bit
        add_level(1'b1, 5);
        add_level(1'b0, 3);
        add_level(1'b1, 20);
        add_frame(16, 8'hC3, 1'b1);
        add_level(1'b1, 20);
        run(16);
        check("c16_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("c16_byte", 32'(got_q[0]), 32'hC3);

        // Transmitter-style loopback stream
        add_level(1'b1, 3);
        for (int i = 0; i < 8; i++) add_frame(1, lb[i], 1'b1);
        add_level(1'b1, 5);
        run(1);
        check("lb_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check($sformatf("lb_byte%0d", i), 32'(got_q[i]), 32'(lb[i]));

        // Random streams at both bit rates
        for (int pass = 0; pass < 2; pass++) begin
            cc = (pass == 0) ? 1 : 16;
            add_level(1'b1, 2);
            for (int f = 0; f < 10; f++) begin
                rb = 8'($urandom);
                if (cc == 16 && $urandom_range(0, 3) == 0) begin
                    add_level(1'b0, $urandom_range(1, 7));
                    add_level(1'b1, $urandom_range(8, 20));
                end
                if ($urandom_range(0, 7) == 0) begin
                    add_frame(cc, rb, 1'b0);
                    add_level(1'b0, $urandom_range(0, 2 * cc));
                    add_level(1'b1, 1);
                end else begin
                    add_frame(cc, rb, 1'b1);
                end
                add_level(1'b1, $urandom_range(0, 3 * cc));
            end
            add_level(1'b1, 2 * cc + 20);
            run(cc);
        end

        // Reset in the middle of a frame
        do_reset();
        add_level(1'b1, 2);
        add_frame(1, 8'hA5, 1'b1);
        add_level(1'b1, 2);
        add_level(1'b0, 1);
        add_level(1'b1, 1);
        add_level(1'b0, 1);
        add_level(1'b1, 1);
        add_level(1'b0, 1);
        run(1);
        check("pre_rst_data", 32'(data1), 32'hA5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(data1), 32'h00);
        check("midrst_recv", 32'(recv1), 32'h0);
        rx1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data1 = 8'h00;
        add_level(1'b1, 2);
        add_frame(1, 8'h55, 1'b1);
        add_level(1'b1, 4);
        run(1);
        check("post_rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("post_rst_byte", 32'(got_q[0]), 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Simplified UART receiver. Deserialises an 8N1 serial stream on `rx` into bytes and pulses `received` for one clock when a valid frame completes. Sits downstream of the UART transmitter state machine and feeds the byte sink / file logger. Bit timing is derived from the system clock by a fixed clocks-per-bit count; there is no oversampling voter.

Parameters:
CLKS_PER_BIT, 1, system clock cycles per serial bit (legal ≥1); the integration bench uses 1 (one bit per clk).
DATA_BITS, 8, payload bits per frame; LSB first.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, idle high
data  output  8  last correctly received byte; held until the next valid frame
received  output  1  one-cycle strobe, high in the cycle data is updated

Behaviour:
- Reset (async, active-high, any time including mid-frame): state=IDLE, data=8'h00, received=0, counters=0, shift register=0.
- Frame: start bit 0, DATA_BITS data bits LSB first, one stop bit 1. No parity.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on a rising edge with rx==0, go to START and clear the bit counter. Let H = (CLKS_PER_BIT-1)/2 (integer division) and t0 = the detecting edge.
- START: at t0+H, re-sample rx. If 0, go to DATA. If 1, treat as a glitch and return to IDLE. When CLKS_PER_BIT=1, H=0 and the detecting edge is itself the check; go straight to DATA.
- DATA: sample rx at t0+H+k·CLKS_PER_BIT for k=1..DATA_BITS. Shift right into the shift register so that bit k lands at data[k-1]. After k=DATA_BITS, go to STOP.
- STOP: sample at t0+H+(DATA_BITS+1)·CLKS_PER_BIT.
  - rx==1: on that same edge, data<=shift register and received<=1; next state IDLE.
  - rx==0 (framing error): data unchanged, received stays 0; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx==1 is sampled, then go to IDLE. This prevents a break condition being read as back-to-back 0x00 frames.
- received: high for exactly one clk cycle per valid frame; never two consecutive cycles.
- data: stable between strobes.
- Back-to-back frames: a start bit immediately following the stop bit is detected on the next edge. With CLKS_PER_BIT=1, frame n+1's start bit is sampled on the edge right after the stop-sample edge, giving a sustained throughput of 1 byte / 10 clk.
- Latency with CLKS_PER_BIT=1: received rises on the 10th rising edge counting the start-detect edge as the 1st.
- rx is used unsynchronised; the source is synchronous to clk inside the design.
- Counter widths: clog2(CLKS_PER_BIT+1) for the baud counter, 4 bits for the bit counter. The baud counter wraps to 0 at CLKS_PER_BIT-1.

Optional Feature:
Macro UART_RX_FRAME_ERR_EN.
- Defined: adds output `frame_err` (1 bit, reset 0). It pulses high for one cycle on the STOP-sample edge when rx==0; never coincident with received.
- Undefined: no port; framing errors are silently dropped. All other behaviour is identical, including WAIT_HIGH.

Decomposition:
- Package uart_pkg:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH);
  - constants `UART_DATA_BITS=8`, `UART_START_LVL=1'b0`, `UART_STOP_LVL=1'b1`, `UART_IDLE_LVL=1'b1`.
  - Shared with the transmitter state machine.
- One sub-module is natural: `uart_baud_tick`, a CLKS_PER_BIT counter with a sync restart input and a one-cycle tick output at the half-bit and full-bit points.
- Everything else stays in uart_rx.

Test Plan:
- Reset mid-frame: assert rst after the 4th data bit of 0x55 → data=00, received=0, state IDLE immediately. A following clean 0x55 frame is received correctly.
- Single frame, CLKS_PER_BIT=1: rx = 0,1,0,0,0,0,0,1,0,1 (0x41 'A') → received high for exactly 1 cycle on the 10th edge; data=8'h41 and held afterwards.
- Back-to-back: frames 0x48, 0x69, 0x0A with no idle gap → three strobes spaced exactly 10 clk apart; data = 48, 69, 0A in order.
- Framing error: 0xA5 with stop bit 0, then rx held low for 20 clk, then high → no strobe, data keeps its prior value, no spurious 0x00 frame. frame_err pulses once when UART_RX_FRAME_ERR_EN is defined.
- Glitch rejection, CLKS_PER_BIT=16: rx low for 3 clk then high → no strobe, back to IDLE. A full 16-clk/bit frame of 0xC3 → data=C3, one strobe.
- Loopback with the transmitter over 0x00, 0xFF and ASCII "Hello\n" → bytes emitted in identical order; number of strobes equals number of bytes sent.
